// File: rtl/game_seq_pkg.sv
// Shared types, constants and helpers for the game sequencer.
// Provides the state enum, lives limit and the stage-map mask extractor.
package game_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_RESPAWN,
    S_TRANS,
    S_OVER,
    S_WON
  } game_seq_state_t;

  localparam int MAX_LIVES  = 15;
  localparam int MAX_MAP_W  = 256;
  localparam int MAX_GROUPS = 32;

  // Group mask of one stage; bits at and above ng are zero.
  function automatic logic [MAX_GROUPS-1:0] stage_mask(
    input logic [MAX_MAP_W-1:0] map,
    input int                   stage,
    input int                   ng
  );
    logic [MAX_MAP_W-1:0]  sh;
    logic [MAX_GROUPS-1:0] keep;
    sh   = map >> (stage * ng);
    keep = '1;
    if (ng < MAX_GROUPS) keep = ~(keep << ng);
    return sh[MAX_GROUPS-1:0] & keep;
  endfunction

endpackage

// File: rtl/game_sequencer_phase_timer.sv
// Down-counter for timed phases (respawn, stage transition).
// Ports: clk, resetN, load, load_val -> done (high while count is 1).
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loaded with N on entry, so done at 1 ends the phase after N cycles.
  assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/game_sequencer.sv
// Stage / lives / transition sequencer driving player and enemy groups.
// Ports: clk, resetN, start_game, pause, skip_stage, win_stage,
//   player_dead -> enable/resetN for player and groups, stage_num,
//   lives_left, in_transition, game_won, game_over.
// Optional lives counter and respawn phase: GAME_SEQ_LIVES_EN.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int NUM_GROUPS     = 3,
  parameter logic [NUM_STAGES*NUM_GROUPS-1:0] STAGE_MAP = 12'b100_010_011,
  parameter int LIVES          = 3,
  parameter int TRANS_CYCLES   = 1024,
  parameter int RESPAWN_CYCLES = 512,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start_game,
  input  logic                  pause,
  input  logic                  skip_stage,
  input  logic                  win_stage,
  input  logic                  player_dead,
  output logic                  enable_player,
  output logic                  resetN_player,
  output logic [NUM_GROUPS-1:0] enable_group,
  output logic [NUM_GROUPS-1:0] resetN_group,
  output logic [SW-1:0]         stage_num,
  output logic [3:0]            lives_left,
  output logic                  in_transition,
  output logic                  game_won,
  output logic                  game_over
);

`ifdef GAME_SEQ_LIVES_EN
  localparam int TMAX = (TRANS_CYCLES > RESPAWN_CYCLES) ?
                        TRANS_CYCLES : RESPAWN_CYCLES;
  localparam logic [3:0] INIT_LIVES =
    4'((LIVES > MAX_LIVES) ? MAX_LIVES : LIVES);
`else
  localparam int TMAX = TRANS_CYCLES;
  localparam int unused_params = LIVES + RESPAWN_CYCLES + MAX_LIVES;
`endif
  localparam int TW = $clog2(TMAX + 1);

  game_seq_state_t state;

  logic          stable_start;
  logic          stable_pause;
  logic          skip_q;
  logic          skip_pulse;
  logic          win_cond;
  logic          run_live;
  logic          dead_ev;
  logic          win_ev;
  logic          last_stage;
  logic          last_life;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  logic [MAX_GROUPS-1:0] mask_full;
  logic [NUM_GROUPS-1:0] grp_mask;
  logic                  unused_mask;

`ifdef GAME_SEQ_LIVES_EN
  logic [3:0] lives;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stable_start <= 1'b0;
      stable_pause <= 1'b0;
      skip_q       <= 1'b0;
    end else begin
      stable_start <= start_game;
      stable_pause <= pause;
      skip_q       <= skip_stage;
    end
  end

  assign skip_pulse = skip_stage & ~skip_q;
  assign win_cond   = win_stage | skip_pulse;

  // RUN events as the FSM resolves them: pause, then death, then win.
  assign run_live   = (state == S_RUN) & stable_start & ~stable_pause;
  assign dead_ev    = run_live & player_dead;
  assign win_ev     = run_live & ~player_dead & win_cond;
  assign last_stage = (stage_num == SW'(NUM_STAGES - 1));

`ifdef GAME_SEQ_LIVES_EN
  assign last_life  = (lives == 4'd1);
  assign lives_left = lives;
`else
  assign last_life  = 1'b1;
  assign lives_left = 4'd0;
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state == S_IDLE) begin
      tmr_load = 1'b1;
`ifdef GAME_SEQ_LIVES_EN
    end else if (dead_ev && !last_life) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(RESPAWN_CYCLES);
`endif
    end else if (win_ev && !last_stage) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(TRANS_CYCLES);
    end
  end

  phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (clk),
    .resetN  (resetN),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      stage_num <= '0;
`ifdef GAME_SEQ_LIVES_EN
      lives     <= INIT_LIVES;
`endif
    end else if (state != S_IDLE && !stable_start) begin
      // Clear on the way out so IDLE never shows stale progress.
      state     <= S_IDLE;
      stage_num <= '0;
`ifdef GAME_SEQ_LIVES_EN
      lives     <= INIT_LIVES;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          stage_num <= '0;
`ifdef GAME_SEQ_LIVES_EN
          lives     <= INIT_LIVES;
`endif
          if (stable_start) state <= S_RUN;
        end
        S_RUN: begin
          if (stable_pause) begin
            state <= S_PAUSE;
          end else if (dead_ev) begin
`ifdef GAME_SEQ_LIVES_EN
            lives <= lives - 4'd1;
            state <= last_life ? S_OVER : S_RESPAWN;
`else
            state <= S_OVER;
`endif
          end else if (win_ev) begin
            state <= last_stage ? S_WON : S_TRANS;
          end
        end
        S_PAUSE: begin
          if (!stable_pause) state <= S_RUN;
        end
        S_RESPAWN: begin
          if (tmr_done) state <= S_RUN;
        end
        S_TRANS: begin
          if (tmr_done) begin
            state     <= S_RUN;
            stage_num <= stage_num + 1'b1;
          end
        end
        S_OVER, S_WON: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mask_full = stage_mask(MAX_MAP_W'(STAGE_MAP),
                                int'(stage_num), NUM_GROUPS);
  assign grp_mask    = mask_full[NUM_GROUPS-1:0];
  assign unused_mask = ^mask_full;

  always_comb begin
    enable_player = 1'b0;
    resetN_player = 1'b0;
    enable_group  = '0;
    resetN_group  = '0;
    in_transition = 1'b0;
    game_won      = 1'b0;
    game_over     = 1'b0;
    unique case (1'b1)
      (state == S_RUN): begin
        enable_player = 1'b1;
        resetN_player = 1'b1;
        enable_group  = grp_mask;
        resetN_group  = grp_mask;
      end
      (state == S_PAUSE): begin
        resetN_player = 1'b1;
        resetN_group  = grp_mask;
      end
      // Groups keep their state while the player respawns.
      (state == S_RESPAWN): begin
        resetN_group  = grp_mask;
      end
      (state == S_TRANS): begin
        enable_player = 1'b1;
        resetN_player = 1'b1;
        in_transition = 1'b1;
      end
      (state == S_OVER): game_over = 1'b1;
      (state == S_WON):  game_won  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised and directed bench for game_sequencer.
// Compares every cycle against a behavioural model of the game rules.
module tb_game_sequencer;

  localparam int NS = 4;
  localparam int NG = 3;
  localparam logic [11:0] MAP = 12'b100_010_011;
  localparam int LV = 3;
  localparam int TC = 1024;
  localparam int RC = 512;
`ifdef GAME_SEQ_LIVES_EN
  localparam bit LIVES_ON = 1'b1;
  localparam int LV0 = LV;
`else
  localparam bit LIVES_ON = 1'b0;
  localparam int LV0 = 0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_RESP  = 3;
  localparam int M_TRANS = 4;
  localparam int M_OVER  = 5;
  localparam int M_WON   = 6;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic start_game = 1'b0;
  logic pause = 1'b0;
  logic skip_stage = 1'b0;
  logic win_stage = 1'b0;
  logic player_dead = 1'b0;
  logic enable_player;
  logic resetN_player;
  logic [NG-1:0] enable_group;
  logic [NG-1:0] resetN_group;
  logic [1:0] stage_num;
  logic [3:0] lives_left;
  logic in_transition;
  logic game_won;
  logic game_over;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase, m_stage, m_lives, m_left;
  bit m_start_d, m_pause_d, m_skip_d;

  game_sequencer #(
    .NUM_STAGES(NS), .NUM_GROUPS(NG), .STAGE_MAP(MAP),
    .LIVES(LV), .TRANS_CYCLES(TC), .RESPAWN_CYCLES(RC)
  ) dut (
    .clk(clk), .resetN(resetN),
    .start_game(start_game), .pause(pause),
    .skip_stage(skip_stage), .win_stage(win_stage),
    .player_dead(player_dead),
    .enable_player(enable_player), .resetN_player(resetN_player),
    .enable_group(enable_group), .resetN_group(resetN_group),
    .stage_num(stage_num), .lives_left(lives_left),
    .in_transition(in_transition), .game_won(game_won),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = M_IDLE;
    m_stage = 0;
    m_lives = LV0;
    m_left = 0;
    m_start_d = 0;
    m_pause_d = 0;
    m_skip_d = 0;
  endtask

  task automatic model_edge();
    bit win;
    if (!resetN) begin
      model_reset();
      return;
    end
    win = win_stage || (skip_stage && !m_skip_d);
    if (m_phase != M_IDLE && !m_start_d) begin
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (m_start_d) m_phase = M_RUN;
        M_RUN: begin
          if (m_pause_d) m_phase = M_PAUSE;
          else if (player_dead) begin
            if (LIVES_ON) begin
              m_lives = m_lives - 1;
              if (m_lives == 0) m_phase = M_OVER;
              else begin
                m_phase = M_RESP;
                m_left = RC;
              end
            end else m_phase = M_OVER;
          end else if (win) begin
            if (m_stage == NS - 1) m_phase = M_WON;
            else begin
              m_phase = M_TRANS;
              m_left = TC;
            end
          end
        end
        M_PAUSE: if (!m_pause_d) m_phase = M_RUN;
        M_RESP: begin
          m_left--;
          if (m_left == 0) m_phase = M_RUN;
        end
        M_TRANS: begin
          m_left--;
          if (m_left == 0) begin
            m_stage++;
            m_phase = M_RUN;
          end
        end
        default: ;
      endcase
    end
    if (m_phase == M_IDLE) begin
      m_stage = 0;
      m_lives = LV0;
    end
    m_start_d = start_game;
    m_pause_d = pause;
    m_skip_d = skip_stage;
  endtask

  function automatic logic [31:0] model_vec();
    logic [11:0] sh;
    logic [2:0] mk;
    logic it, wn, ov, ep, rp;
    logic [2:0] eg, rg;
    sh = MAP >> (m_stage * NG);
    mk = sh[2:0];
    {it, wn, ov, ep, rp, eg, rg} = '0;
    case (m_phase)
      M_RUN: begin ep = 1; rp = 1; eg = mk; rg = mk; end
      M_PAUSE: begin rp = 1; rg = mk; end
      M_RESP: rg = mk;
      M_TRANS: begin ep = 1; rp = 1; it = 1; end
      M_OVER: ov = 1;
      M_WON: wn = 1;
      default: ;
    endcase
    return 32'({it, wn, ov, ep, rp, eg, rg,
                2'(m_stage), 4'(m_lives)});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({in_transition, game_won, game_over,
                enable_player, resetN_player,
                enable_group, resetN_group,
                stage_num, lives_left});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("outputs", dut_vec(), model_vec());
    end
  endtask

  task automatic win_pulse();
    win_stage = 1;
    step(1);
    win_stage = 0;
  endtask

  task automatic dead_pulse();
    player_dead = 1;
    step(1);
    player_dead = 0;
  endtask

  initial begin
    int cnt;
    model_reset();
    step(3);
    check("reset_vals", dut_vec(), 32'(LV0));

    resetN = 1;
    step(1);
    start_game = 1;
    step(2);
    check("run_en_player", 32'(enable_player), 1);
    check("run_en_group", 32'(enable_group), 3'b011);
    check("run_rstn_g2", 32'(resetN_group[2]), 0);
    check("run_stage", 32'(stage_num), 0);
    step(5);

    skip_stage = 1;
    step(1);
    cnt = 0;
    while (in_transition === 1'b1 && cnt < 3000) begin
      cnt++;
      if (cnt == 19) skip_stage = 0;
      step(1);
    end
    skip_stage = 0;
    check("trans_len", 32'(cnt), TC);
    check("stage_after_skip", 32'(stage_num), 1);
    check("en_group_stage1", 32'(enable_group), 3'b010);
    step(30);
    check("single_advance", 32'(stage_num), 1);

    pause = 1;
    step(2);
    check("pause_en", 32'({enable_player, enable_group}), 0);
    pause = 0;
    step(2);
    check("unpause_en", 32'(enable_player), 1);

    player_dead = 1;
    win_stage = 1;
    step(1);
    player_dead = 0;
    win_stage = 0;
    check("sim_stage", 32'(stage_num), 1);
    if (LIVES_ON) begin
      check("sim_lives", 32'(lives_left), LV - 1);
      cnt = 0;
      while (resetN_player === 1'b0 && cnt < 2000) begin
        cnt++;
        step(1);
      end
      check("respawn_len", 32'(cnt), RC);
      dead_pulse();
      check("lives_1", 32'(lives_left), 1);
      step(RC);
      check("back_run", 32'(enable_player), 1);
      dead_pulse();
      check("over_lives", 32'(lives_left), 0);
    end
    check("game_over", 32'(game_over), 1);
    step(4);

    start_game = 0;
    step(2);
    check("idle_over", 32'({game_over, stage_num}), 0);
    start_game = 1;
    step(2);
    for (int s = 0; s < NS - 1; s++) begin
      win_pulse();
      step(TC);
    end
    check("stage_last", 32'(stage_num), NS - 1);
    win_pulse();
    check("game_won", 32'(game_won), 1);
    step(3);
    start_game = 0;
    step(2);
    check("idle_won", 32'(game_won), 0);

    start_game = 1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) start_game = ~start_game;
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      if ($urandom_range(0, 7) == 0) skip_stage = ~skip_stage;
      win_stage = ($urandom_range(0, 99) < 2);
      player_dead = ($urandom_range(0, 199) < 2);
      resetN = ($urandom_range(0, 1999) != 0);
      step(1);
    end

    resetN = 1;
    {start_game, pause, skip_stage, win_stage, player_dead} = '0;
    step(3);
    start_game = 1;
    step(3);
    win_pulse();
    step(10);
    check("pre_reset_trans", 32'(in_transition), 1);
    resetN = 0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), 32'(LV0));
    step(2);
    resetN = 1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
